// File: rtl/uncached_pkg.sv
// uncached_pkg: shared types and defaults for the uncached access buffer.
package uncached_pkg;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [2:0] {IDLE, W_REQ, W_ACK, R_REQ, R_WAIT} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  size;
    } entry_t;
endpackage

// File: rtl/ubuf_fifo.sv
// ubuf_fifo: posted-write queue; DEPTH is a power of two so pointers wrap naturally.
module ubuf_fifo
    import uncached_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  logic   pop_i,
    input  entry_t wr_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);
    localparam int PW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [PW:0]   count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + PW'(1);
            if (pop_i) head_q <= head_q + PW'(1);
            count_q <= count_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= wr_i;
    end

    assign head_o  = mem_q[head_q];
    assign full_o  = count_q == DEPTH[PW:0];
    assign empty_o = count_q == '0;
endmodule

// File: rtl/uncached_buffer.sv
// uncached_buffer: posts stores through a FIFO and serialises them with blocking loads
// onto a single-outstanding bus channel in program order.
module uncached_buffer
    import uncached_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [1:0]  req_size,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic [1:0]  bus_size,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_wack
);
    state_t      state_q;
    entry_t      head, wr;
    logic        full, empty, store_ok, load_ok, pop;
    logic        bus_valid_q, bus_we_q, resp_valid_q;
    logic [31:0] bus_addr_q, bus_wdata_q, resp_rdata_q;
    logic [3:0]  bus_wstrb_q;
    logic [1:0]  bus_size_q;

    assign wr       = '{addr: req_addr, wdata: req_wdata, wstrb: req_wstrb, size: req_size};
    assign store_ok = req_valid & req_we & ~full;
    // Loads wait for every earlier store to drain and complete before issuing.
    assign load_ok  = req_valid & ~req_we & empty & (state_q == IDLE);
    assign pop      = (state_q == W_REQ) & bus_ready;
    assign req_ready = ~rst & (store_ok | load_ok);

    ubuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (store_ok),
        .pop_i   (pop),
        .wr_i    (wr),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bus_valid_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wstrb_q  <= '0;
            bus_size_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q     <= W_REQ;
                        bus_valid_q <= 1'b1;
                        bus_we_q    <= 1'b1;
                        bus_addr_q  <= head.addr;
                        bus_wdata_q <= head.wdata;
                        bus_wstrb_q <= head.wstrb;
                        bus_size_q  <= head.size;
                    end else if (load_ok) begin
                        state_q     <= R_REQ;
                        bus_valid_q <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= req_addr;
                        bus_wdata_q <= '0;
                        bus_wstrb_q <= '0;
                        bus_size_q  <= req_size;
                    end
                end
                W_REQ: begin
                    if (bus_ready) begin
                        state_q     <= W_ACK;
                        bus_valid_q <= 1'b0;
                    end
                end
                W_ACK: begin
                    if (bus_wack) state_q <= IDLE;
                end
                R_REQ: begin
                    if (bus_ready) begin
                        state_q     <= R_WAIT;
                        bus_valid_q <= 1'b0;
                    end
                end
                R_WAIT: begin
                    if (bus_rvalid) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= bus_rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_valid  = bus_valid_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_wstrb  = bus_wstrb_q;
    assign bus_size   = bus_size_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_uncached_buffer.sv
// tb_uncached_buffer: directed scenarios against a transaction-level model of the
// buffer (in-order request queue, store occupancy, expected load responses).
module tb_uncached_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, resp_valid;
    logic [31:0] resp_rdata;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [1:0]  bus_size;
    logic        bus_ready = 1'b0, bus_wack = 1'b0, auto_rv = 1'b0, stray_rv = 1'b0, rd_en = 1'b1;
    logic        bus_rvalid;
    logic [31:0] bus_rdata = '0;

    assign bus_rvalid = auto_rv | stray_rv;

    uncached_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_size(req_size), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_size(bus_size),
        .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_wack(bus_wack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus slave: acknowledges stores and answers loads one cycle after the handshake.
    logic [31:0] mem [logic [31:0]];
    always @(posedge clk) begin : responder
        logic hs, we;
        logic [31:0] a, d;
        hs = bus_valid & bus_ready;
        we = bus_we;
        a  = bus_addr;
        d  = bus_wdata;
        #1;
        bus_wack = hs & we;
        auto_rv  = hs & !we & rd_en;
        if (hs & we) mem[a] = d;
        bus_rdata = (hs & !we) ? (mem.exists(a) ? mem[a] : ~a) : 32'h0BAD_0BAD;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr, wdata;
        logic [3:0]  wstrb;
        logic [1:0]  size;
    } tx_t;

    tx_t         txq[$];
    bit          issued = 0, resp_due = 0, prev_stall = 0;
    int          mcount = 0, wack_cyc = 0, acc_cyc = 0;
    logic [31:0] resp_exp = '0, rdata_last = '0;
    logic [71:0] prev_bus = '0;
    logic [31:0] hs_addr[$], hs_data[$];

    always @(negedge clk) begin : model
        logic exp_rdy;
        tx_t  t;
        if (rst) begin
            txq.delete();
            issued = 0; resp_due = 0; prev_stall = 0; mcount = 0; rdata_last = '0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_bus_valid", bus_valid, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_count", dut.u_fifo.count_q, 0);
        end else begin
            exp_rdy = req_valid && (req_we ? (mcount < DEPTH) : (txq.size() == 0));
            chk("req_ready", req_ready, exp_rdy);
            chk("count", dut.u_fifo.count_q, mcount);
            chk("resp_valid", resp_valid, resp_due);
            chk("resp_rdata", resp_rdata, resp_due ? resp_exp : rdata_last);
            if (resp_due) rdata_last = resp_exp;
            resp_due = 0;
            if (!(txq.size() > 0 && !issued)) chk("bus_valid_idle", bus_valid, 0);
            if (prev_stall) chk("bus_hold", {bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_size}, prev_bus);
            if (issued && txq[0].we && bus_wack) begin
                void'(txq.pop_front());
                issued = 0;
                wack_cyc = cyc;
            end else if (issued && !txq[0].we && bus_rvalid) begin
                resp_due = 1;
                resp_exp = bus_rdata;
                void'(txq.pop_front());
                issued = 0;
            end
            if (bus_valid && txq.size() > 0 && !issued) begin
                t = txq[0];
                chk("bus_we", bus_we, t.we);
                chk("bus_addr", bus_addr, t.addr);
                chk("bus_size", bus_size, t.size);
                chk("bus_wstrb", bus_wstrb, t.we ? t.wstrb : 4'h0);
                if (t.we) chk("bus_wdata", bus_wdata, t.wdata);
                if (bus_ready) begin
                    issued = 1;
                    if (t.we) mcount--;
                    hs_addr.push_back(bus_addr);
                    hs_data.push_back(bus_wdata);
                end
            end
            prev_stall = bus_valid && !bus_ready;
            prev_bus = {bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_size};
            if (exp_rdy) begin
                t = '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb, size: req_size};
                txq.push_back(t);
                if (req_we) mcount++;
                acc_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bit got = 0;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
        req_wstrb = we ? 4'hF : 4'h0; req_size = sz;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
            step();
        end
        req_valid = 0;
        chk("req_accept", got, 1);
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((txq.size() != 0 || resp_due) && i < 200) begin
            step();
            i++;
        end
        chk("drain", i < 200, 1);
        step();
    endtask

    task automatic wait_resp(output int pulses, output logic [31:0] d);
        pulses = 0;
        d = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                pulses++;
                d = resp_rdata;
            end
        end
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulses;
        logic [31:0] rd;
        repeat (3) step();
        chk("reset_bus_addr", bus_addr, 0);
        chk("reset_resp_rdata", resp_rdata, 0);
        rst = 0;
        step();

        // Three posted stores drain in order.
        bus_ready = 1;
        hs_addr.delete(); hs_data.delete();
        for (int i = 0; i < 3; i++) do_req(1, 32'h1FD0_0000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 2);
        wait_idle();
        chk("s1_hs_count", hs_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("s1_hs_addr", hs_addr[i], 32'h1FD0_0000 + 32'(4 * i));
            chk("s1_hs_data", hs_data[i], 32'h1111_0000 + 32'(i));
        end
        chk("s1_count", dut.u_fifo.count_q, 0);

        // Fill the FIFO with the bus stalled; the fifth store waits for the first pop.
        bus_ready = 0;
        hs_addr.delete(); hs_data.delete();
        for (int i = 0; i < 4; i++) do_req(1, 32'h1FD1_0000 + 32'(4 * i), 32'h2222_0000 + 32'(i), 2);
        req_valid = 1; req_we = 1; req_addr = 32'h1FD1_0010; req_wdata = 32'h2222_0004; req_wstrb = 4'hF; req_size = 2;
        @(negedge clk);
        chk("s2_full_ready", req_ready, 0);
        chk("s2_full_count", dut.u_fifo.count_q, 4);
        step(); step();
        bus_ready = 1;
        @(negedge clk);
        chk("s2_pop_cycle_ready", req_ready, 0);
        step();
        @(negedge clk);
        chk("s2_after_pop_ready", req_ready, 1);
        step();
        req_valid = 0;
        wait_idle();
        chk("s2_hs_count", hs_data.size(), 5);
        for (int i = 0; i < 5; i++) chk("s2_hs_data", hs_data[i], 32'h2222_0000 + 32'(i));

        // A load behind a store to the same address waits for the write ack.
        do_req(1, 32'h1FAF_0000, 32'hDEAD_BEEF, 2);
        do_req(0, 32'h1FAF_0000, 32'h0, 2);
        chk("s3_load_after_wack", acc_cyc, wack_cyc + 1);
        wait_resp(pulses, rd);
        chk("s3_resp_pulses", pulses, 1);
        chk("s3_resp_data", rd, 32'hDEAD_BEEF);
        wait_idle();

        // Stalled load keeps its request fields stable.
        bus_ready = 0;
        hs_addr.delete(); hs_data.delete();
        do_req(0, 32'h1FC0_0010, 32'h0, 1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("s4_valid", bus_valid, 1);
            chk("s4_addr", bus_addr, 32'h1FC0_0010);
            chk("s4_size", bus_size, 1);
            chk("s4_we", bus_we, 0);
            chk("s4_wstrb", bus_wstrb, 0);
            step();
        end
        bus_ready = 1;
        step();
        bus_ready = 0;
        wait_resp(pulses, rd);
        chk("s4_resp_pulses", pulses, 1);
        chk("s4_resp_data", rd, 32'hE03F_FFEF);
        wait_idle();
        chk("s4_hs_count", hs_addr.size(), 1);

        // Reset while a load is in flight and two stores are queued.
        bus_ready = 1;
        rd_en = 0;
        do_req(0, 32'h1FE0_0000, 32'h0, 2);
        do_req(1, 32'h1FE0_0004, 32'h4444_0000, 2);
        do_req(1, 32'h1FE0_0008, 32'h4444_0001, 2);
        req_valid = 1; req_we = 1; req_addr = 32'h1FE0_000C; req_wdata = 32'h4444_0002; req_wstrb = 4'hF; req_size = 2;
        #2;
        rst = 1;
        #1;
        chk("s5_bus_valid", bus_valid, 0);
        chk("s5_bus_we", bus_we, 0);
        chk("s5_bus_addr", bus_addr, 0);
        chk("s5_bus_wdata", bus_wdata, 0);
        chk("s5_bus_wstrb", bus_wstrb, 0);
        chk("s5_bus_size", bus_size, 0);
        chk("s5_resp_valid", resp_valid, 0);
        chk("s5_resp_rdata", resp_rdata, 0);
        chk("s5_req_ready", req_ready, 0);
        chk("s5_count", dut.u_fifo.count_q, 0);
        req_valid = 0;
        step(); step();
        rst = 0;
        rd_en = 1;
        stray_rv = 1;
        step();
        stray_rv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s5_stray_resp", resp_valid, 0);
            chk("s5_stray_bus", bus_valid, 0);
            step();
        end

        // Push and pop together at count 2, then wrap the tail.
        bus_ready = 0;
        hs_addr.delete(); hs_data.delete();
        do_req(1, 32'h1FD2_0000, 32'h3333_0000, 2);
        do_req(1, 32'h1FD2_0004, 32'h3333_0001, 2);
        req_valid = 1; req_we = 1; req_addr = 32'h1FD2_0008; req_wdata = 32'h3333_0002; req_wstrb = 4'hF; req_size = 2;
        bus_ready = 1;
        @(negedge clk);
        chk("s6_pre_count", dut.u_fifo.count_q, 2);
        chk("s6_pushpop_ready", req_ready, 1);
        chk("s6_pushpop_valid", bus_valid, 1);
        step();
        req_valid = 0;
        bus_ready = 0;
        @(negedge clk);
        chk("s6_post_count", dut.u_fifo.count_q, 2);
        step();
        bus_ready = 1;
        for (int i = 3; i < 7; i++) do_req(1, 32'h1FD2_0000 + 32'(4 * i), 32'h3333_0000 + 32'(i), 2);
        wait_idle();
        chk("s6_hs_count", hs_data.size(), 7);
        for (int i = 0; i < 7; i++) chk("s6_hs_data", hs_data[i], 32'h3333_0000 + 32'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uncached_buffer.md
UNCACHED_BUFFER -- requirements
Module: uncached_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of posted-write entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have the following core-side request inputs:
- req_valid (1): core request valid.
- req_we (1): 1 = store, 0 = load.
- req_addr (32): physical address from the address-translation stage, already uncached-qualified.
- req_wdata (32): store data.
- req_wstrb (4): byte enables.
- req_size (2): access size, 0 = byte, 1 = half, 2 = word.
REQ-005 SHALL have the following core-side outputs:
- req_ready (1): request accepted this cycle.
- resp_valid (1): load data valid.
- resp_rdata (32): load data.
REQ-006 SHALL have the following bus-side outputs:
- bus_valid (1), bus_we (1), bus_addr (32), bus_wdata (32), bus_wstrb (4), bus_size (2): one request channel.
REQ-007 SHALL have the following bus-side inputs:
- bus_ready (1): request accepted.
- bus_rvalid (1): read data valid.
- bus_rdata (32): read data.
- bus_wack (1): write complete.

Function
REQ-008 SHALL accept a store (req_valid & req_we) in any cycle where FIFO count < DEPTH, asserting req_ready combinationally that cycle (posted write; no response).
REQ-009 SHALL accept a load only when the FIFO is empty, no write is outstanding, and FSM = IDLE; otherwise req_ready = 0 for loads.
REQ-010 SHALL use FSM states IDLE, W_REQ, W_ACK, R_REQ, R_WAIT.
REQ-011 SHALL transition as follows:
- IDLE -> W_REQ when the FIFO is non-empty.
- IDLE -> R_REQ on load acceptance.
- W_REQ -> W_ACK on bus_valid & bus_ready.
- W_ACK -> IDLE on bus_wack.
- R_REQ -> R_WAIT on bus_ready.
- R_WAIT -> IDLE on bus_rvalid.
REQ-012 SHALL pop the FIFO head on the W_REQ bus handshake.
REQ-013 SHALL keep bus_valid and all bus_* request fields stable from assertion until bus_ready is sampled high.
REQ-014 SHALL register the load request (addr, size) at acceptance, with wstrb driven 0 and we driven 0 in R_REQ.
REQ-015 SHALL assert resp_valid for exactly one cycle, the cycle after bus_rvalid, with resp_rdata = the registered bus_rdata.
REQ-016 SHALL, on simultaneous push and pop, leave count unchanged, write the new entry at the tail, and advance the head.
REQ-017 SHALL NOT let a store arriving when count = DEPTH bypass the FIFO, even if a pop occurs the same cycle; req_ready = 0.
REQ-018 SHALL wrap head and tail pointers modulo DEPTH, with count held in $clog2(DEPTH)+1 bits.
REQ-019 SHALL ignore bus_rvalid outside R_WAIT and bus_wack outside W_ACK.
REQ-020 SHALL keep exactly one bus transaction outstanding at a time, in strict program order.
REQ-021 SHALL hold resp_rdata at its last value when resp_valid = 0.

Reset
REQ-022 SHALL, while rst = 1, asynchronously force:
- FSM = IDLE; head = tail = count = 0.
- bus_valid = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, bus_wstrb = 0, bus_size = 0.
- resp_valid = 0, resp_rdata = 0.
- req_ready = 0.
REQ-023 SHALL, on reset mid-transaction, discard all buffered stores and any in-flight access; post-reset bus responses are ignored per REQ-019.

Structure
REQ-024 SHALL place the FSM state enum, the entry struct (addr, wdata, wstrb, size) and the DEPTH default in shared package uncached_pkg.
REQ-025 SHALL implement storage as sub-module ubuf_fifo, which holds the entry array, pointers, count, full and empty flags.

Verification
REQ-026 SHALL cover: 3 stores to 0x1FD0_0000/04/08 with bus_ready = 1 and bus_wack 1 cycle later -> three W_REQ handshakes in order with matching wdata, count returns to 0.
REQ-027 SHALL cover: 5 back-to-back stores with bus_ready = 0, DEPTH = 4 -> req_ready low on the 5th store, count = 4; release bus_ready -> 5th store accepted the cycle after the first pop.
REQ-028 SHALL cover: store 0xDEADBEEF to 0x1FAF_0000, then a load from same address immediately -> load req_ready = 0 until bus_wack; then bus read issued; bus_rdata = 0xDEADBEEF -> resp_valid pulse with 0xDEADBEEF.
REQ-029 SHALL cover: load with bus_ready held low 7 cycles -> bus_addr/bus_size stable for all 7 cycles; single R_REQ handshake.
REQ-030 SHALL cover: rst asserted in R_WAIT with 2 stores queued -> all outputs at reset values the same cycle; a stray bus_rvalid after reset produces no resp_valid.
REQ-031 SHALL cover: at count = 2, push and pop in the same cycle -> count stays 2, tail wraps correctly after 4 further pushes.
